exu_muldiv: RTL and testbench
=============================

// Module: exu_muldiv
// PURPOSE
//  Multi-cycle RV64M multiply/divide unit beside the single-cycle ALU/branch path in exu.
//  Accepts one op per valid/ready handshake and computes it iteratively:
//  - multiply: shift-add, MUL_STEP bits/cycle
//  - divide: restoring, 1 bit/cycle
//  Holds the result until consumed; a pipeline flush can abort it.
// PARAMETERS
//  XLEN      64  operand/result width; even, >=8
//  MUL_STEP  2   multiplier bits retired per cycle; must divide XLEN/2
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     reset, asynchronous, active-low
//  in_valid   in   1     request valid
//  in_ready   out  1     unit idle, can accept
//  op         in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  word       in   1     RV64 *W variant (only with MULDIV_WORD_EN)
//  a          in   XLEN  rs1 operand (multiplicand/dividend)
//  b          in   XLEN  rs2 operand (multiplier/divisor)
//  flush      in   1     abort current op, drop result
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer takes result
//  out_data   out  XLEN  result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, out_valid=0, out_data=0, busy=0, counters/regs 0.
//  - FSM IDLE->CALC->DONE->IDLE.
//  - in_ready = (state==IDLE) && !flush.
//  - Accept: in_valid && in_ready at edge E0.
//    - Latch op, sign-adjusted magnitudes and result signs.
//    - Enter CALC; iteration count N is set at accept.
//  - N (full width):
//    - mul: XLEN/MUL_STEP (32 @ defaults)
//    - div/rem: XLEN (64)
//    - divisor==0: 1
//    - signed overflow (a==MIN, b==-1, DIV/REM): 1
//  - CALC: one step per edge.
//    - At edge E0+N: apply final sign fix, register out_data, set out_valid=1, enter DONE.
//  - DONE: out_valid and out_data stay stable until out_valid && out_ready, then IDLE.
//    - No accept in the same cycle as the pop (in_ready=0 in DONE).
//  - Arithmetic, RISC-V M semantics:
//    - MUL: low XLEN of the product. MULH/MULHSU/MULHU: high XLEN of the 2*XLEN product.
//    - DIV/REM truncate toward zero; remainder takes the dividend's sign.
//    - Divide by zero: quotient all-ones, remainder = a.
//    - Overflow (MIN / -1): quotient = MIN, remainder = 0.
//  - flush:
//    - Any state: next edge -> IDLE, out_valid=0, result discarded.
//    - Wins over a same-cycle accept (no accept) and over a same-cycle pop (pop ignored).
//  - op/a/b/word are only sampled at accept; later changes have no effect.
//  - rst low mid-operation: immediate IDLE, outputs at reset values.
// CONFIGURATION
//  MULDIV_WORD_EN defined:
//   - word=1: operands are a[31:0]/b[31:0].
//     - signed ops sign-extend them; unsigned ops zero-extend them.
//   - Only MUL/DIV/DIVU/REM/REMU are legal with word=1; word=1 with op 1-3 gives 0.
//   - Result is low 32 bits sign-extended to XLEN.
//   - N halves: XLEN/2/MUL_STEP for mul, XLEN/2 for div.
//   - Word overflow/div-by-zero rules apply at 32 bits.
//  MULDIV_WORD_EN undefined: word is ignored (treated 0); no word datapath is synthesised.
// TESTING (XLEN=64, MUL_STEP=2, accept edge E0)
//  1. MUL a=7, b=-3 -> out_data=0xFFFF_FFFF_FFFF_FFEB, out_valid from E0+32.
//  2. DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD at E0+64; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
//  3. Divide by zero and overflow, each at E0+1:
//     - DIVU a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF
//     - REMU a=5, b=0 -> 5
//     - DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM -> 0
//  4. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
//     MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  5. Handshake and abort:
//     - out_ready low 10 cycles after result -> out_valid, out_data stable, in_ready=0.
//     - flush at cycle 20 of DIV -> out_valid never rises, in_ready=1 next cycle.
//     - rst pulse mid-MUL -> all outputs 0 at once.
//  6. With MULDIV_WORD_EN:
//     - DIV word=1, a=0x0000_0001_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000 at E0+1.
//     - MUL word=1, a=0x1_0000_0003, b=5 -> 0x0000_0000_0000_000F at E0+16.

Source files
------------

// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - iterative RV64M multiply (shift-add) / divide (restoring) unit
// Optional RV64 *W operand support is enabled by defining MULDIV_WORD_EN.
module exu_muldiv #(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic              w_q, neg_q, spec_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   mag_q, spec_val_q;
  logic [2*XLEN-1:0] prod_q;

  logic w;
`ifdef MULDIV_WORD_EN
  assign w = word;
`else
  logic unused_word;
  assign unused_word = word;
  assign w = 1'b0;
`endif

  logic            accept, is_div, sa, sb, a_neg, b_neg, div_zero, ovf, div_spec, illegal;
  logic [XLEN-1:0] ea, eb, ma, mb, min_v, spec_val;
  logic [CW-1:0]   n_iter;

  // Operand conditioning at accept: extension, magnitudes, result sign and special cases.
  always_comb begin
    is_div = op[2];
    sa     = is_div ? ~op[0] : (op == 3'd1 || op == 3'd2);
    sb     = is_div ? ~op[0] : (op == 3'd1);
    ea     = a;
    eb     = b;
    min_v  = {1'b1, {(XLEN-1){1'b0}}};
    if (w) begin
      ea    = sa ? {{H{a[H-1]}}, a[H-1:0]} : {{H{1'b0}}, a[H-1:0]};
      eb    = sb ? {{H{b[H-1]}}, b[H-1:0]} : {{H{1'b0}}, b[H-1:0]};
      min_v = {{(H+1){1'b1}}, {(H-1){1'b0}}};
    end
    a_neg    = sa & ea[XLEN-1];
    b_neg    = sb & eb[XLEN-1];
    ma       = a_neg ? -ea : ea;
    mb       = b_neg ? -eb : eb;
    div_zero = is_div && (eb == '0);
    ovf      = is_div && sa && (ea == min_v) && (&eb);
    div_spec = div_zero || ovf;
    illegal  = w && !is_div && (op != 3'd0);
    spec_val = '0;
    if (div_zero)
      spec_val = op[1] ? ea : '1;
    else if (ovf)
      spec_val = op[1] ? '0 : min_v;
    if (div_spec)
      n_iter = CW'(1);
    else if (is_div)
      n_iter = w ? CW'(H) : CW'(XLEN);
    else
      n_iter = w ? CW'(H / MUL_STEP) : CW'(XLEN / MUL_STEP);
  end

  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [XLEN:0]            div_trial, div_diff;
  logic [XLEN-1:0]          div_rem, q_fix, r_fix, div_res, mul_res, res_pre, res_final;
  logic [2*XLEN-1:0]        step_next, prod_fix;

  // prod_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, prod_q[2*XLEN-1:XLEN]};
    for (int i = 0; i < MUL_STEP; i++)
      if (prod_q[i]) mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, mag_q} << i);
    div_trial = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, mag_q};
    div_rem   = div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
    if (op_q[2])
      step_next = {div_rem, prod_q[XLEN-2:0], ~div_diff[XLEN]};
    else
      step_next = {mul_sum, prod_q[XLEN-1:MUL_STEP]};

    prod_fix = neg_q ? -step_next : step_next;
    q_fix    = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    r_fix    = neg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? r_fix : q_fix;
    // A word multiply retires only H multiplier bits, leaving the low product half in [XLEN-1:H].
    if (w_q)
      mul_res = {{H{1'b0}}, step_next[XLEN-1:H]};
    else
      mul_res = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    res_pre   = spec_q ? spec_val_q : (op_q[2] ? div_res : mul_res);
    res_final = w_q ? {{H{res_pre[H-1]}}, res_pre[H-1:0]} : res_pre;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && !flush) state_d = CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready = (state_q == IDLE) && !flush;
    busy     = (state_q != IDLE);
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      w_q        <= 1'b0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      cnt_q      <= '0;
      mag_q      <= '0;
      prod_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (accept) begin
      op_q       <= op;
      w_q        <= w;
      neg_q      <= (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
      spec_q     <= div_spec || illegal;
      spec_val_q <= spec_val;
      cnt_q      <= n_iter;
      if (is_div) begin
        mag_q  <= mb;
        prod_q <= w ? {{XLEN{1'b0}}, ma[H-1:0], {H{1'b0}}} : {{XLEN{1'b0}}, ma};
      end else begin
        mag_q  <= ma;
        prod_q <= {{XLEN{1'b0}}, mb};
      end
    end else if (state_q == CALC && !flush) begin
      prod_q <= step_next;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        out_data  <= res_final;
        out_valid <= 1'b1;
      end
    end else if (flush || (state_q == DONE && out_ready)) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exu_muldiv.sv
// tb/tb_exu_muldiv.sv - scoreboard bench for exu_muldiv against a plain-arithmetic reference
module tb_exu_muldiv;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, word = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [2:0]  op = 3'd0;
  logic [63:0] a = '0, b = '0, out_data;
  int          total = 0, bad = 0, cyc = 0;
  bit          hold = 1'b0;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct { logic [63:0] data; int vcyc; } exp_t;
  exp_t sb[$];

  exu_muldiv dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .word(word),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [127:0]       px, py, p;
    logic signed [63:0] sx, sy;
    logic signed [31:0] wx, wy;
    logic [31:0]        ux, uy, r;
    sx = x; sy = y;
    if (w) begin
      wx = x[31:0]; wy = y[31:0]; ux = x[31:0]; uy = y[31:0];
      case (o)
        3'd0: r = ux * uy;
        3'd4: r = (uy == 0) ? 32'hFFFF_FFFF :
                  (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(wx / wy);
        3'd5: r = (uy == 0) ? 32'hFFFF_FFFF : ux / uy;
        3'd6: r = (uy == 0) ? ux :
                  (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) ? 32'd0 : 32'(wx % wy);
        3'd7: r = (uy == 0) ? ux : ux % uy;
        default: r = 32'd0;
      endcase
      return {{32{r[31]}}, r};
    end
    case (o)
      3'd0: return x * y;
      3'd1, 3'd2, 3'd3: begin
        px = (o != 3'd3) ? {{64{x[63]}}, x} : {64'd0, x};
        py = (o == 3'd1) ? {{64{y[63]}}, y} : {64'd0, y};
        p  = px * py;
        return p[127:64];
      end
      3'd4: return (y == 0) ? ONES : (x == MIN && y == ONES) ? MIN : 64'(sx / sy);
      3'd5: return (y == 0) ? ONES : x / y;
      3'd6: return (y == 0) ? x : (x == MIN && y == ONES) ? 64'd0 : 64'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    if (!o[2]) return w ? 16 : 32;
    if (w) return (y[31:0] == 0 || (!o[0] && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)) ? 1 : 32;
    return (y == 0 || (!o[0] && x == MIN && y == ONES)) ? 1 : 64;
  endfunction

  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    op = o; word = w; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    check("in_ready_at_issue", 64'(in_ready), 64'd1);
    e.data = model(o, w, x, y);
    e.vcyc = cyc + 1 + lat(o, w, x, y);
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); word = 1'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0, 1:    return {$urandom, $urandom};
      2:       return 64'($urandom_range(0, 20));
      3:       return -64'($urandom_range(1, 20));
      4:       return MIN;
      5:       return ONES;
      default: return 64'd0;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin : monitor
    bit   pv = 1'b0;
    int   fcyc = 0;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (out_valid && !pv) fcyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          check("data", out_data, e.data);
          check("latency", 64'(fcyc), 64'(e.vcyc));
        end
      end
      pv = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;

    issue(3'd0, 1'b0, 64'd7, -64'd3, 1'b1); wait_done();
    issue(3'd4, 1'b0, -64'd7, 64'd2, 1'b1); wait_done();
    issue(3'd6, 1'b0, -64'd7, 64'd2, 1'b1); wait_done();
    issue(3'd5, 1'b0, 64'd5, 64'd0, 1'b1); wait_done();
    issue(3'd7, 1'b0, 64'd5, 64'd0, 1'b1); wait_done();
    issue(3'd4, 1'b0, 64'd5, 64'd0, 1'b1); wait_done();
    issue(3'd6, 1'b0, -64'd5, 64'd0, 1'b1); wait_done();
    issue(3'd4, 1'b0, MIN, ONES, 1'b1); wait_done();
    issue(3'd6, 1'b0, MIN, ONES, 1'b1); wait_done();
    issue(3'd3, 1'b0, ONES, ONES, 1'b1); wait_done();
    issue(3'd2, 1'b0, ONES, 64'd2, 1'b1); wait_done();
    issue(3'd1, 1'b0, MIN, MIN, 1'b1); wait_done();
`ifdef MULDIV_WORD_EN
    issue(3'd4, 1'b1, 64'h0000_0001_8000_0000, ONES, 1'b1); wait_done();
    issue(3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'd5, 1'b1); wait_done();
    issue(3'd1, 1'b1, 64'd9, 64'd9, 1'b1); wait_done();
    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 7)), 1'b1, pick(), pick(), 1'b1); wait_done();
    end
`endif
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 1'b0, pick(), pick(), 1'b1); wait_done();
    end

    // Consumer stalls: result must hold and no new op may be accepted.
    hold = 1'b1;
    issue(3'd0, 1'b0, 64'd1234567, 64'd89, 1'b1);
    for (int i = 0; i < 100 && !out_valid; i++) begin @(negedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", out_data, 64'd109876463);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    hold = 1'b0;
    wait_done();

    // Flush blocks a same-cycle accept.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; flush = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 64'(busy), 64'd0);

    // Flush mid-divide drops the result.
    issue(3'd4, 1'b0, 64'd1000, 64'd3, 1'b0);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (80) begin @(negedge clk); #1; if (out_valid) seen = 1'b1; end
    check("flush_no_result", 64'(seen), 64'd0);

    // Asynchronous reset mid-multiply; out_data still holds the stalled result beforehand.
    issue(3'd1, 1'b0, pick(), pick(), 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", out_data, 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(3'd5, 1'b0, 64'd100, 64'd7, 1'b1); wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
